// File: rtl/cmos_sensor_pattern_gen.sv
// Synthetic CMOS sensor stream generator. It emits frame_valid, line_valid
// and pixel data with runtime-configurable geometry, blanking and test
// pattern, so it can stand in for a real sensor in front of the capture path.
// Frame configuration is sampled only when a frame launches. Every output is
// a register.
module cmos_sensor_pattern_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_value,
  input  logic [DIM_WIDTH-1:0]  frame_width,
  input  logic [DIM_WIDTH-1:0]  frame_height,
  input  logic [DIM_WIDTH-1:0]  line_blank,
  input  logic [DIM_WIDTH-1:0]  frame_blank,
  output logic                  frame_valid,
  output logic                  line_valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           frame_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FBLANK = 2'd1;
  localparam logic [1:0] S_LBLANK = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  localparam logic [1:0] MODE_COUNTER  = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  DIM_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] PIX_ONE = DATA_WIDTH'(1);

  logic [1:0]            state, state_nxt;
  logic [DIM_WIDTH-1:0]  width_q, height_q, lblank_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] const_q;
  logic [DIM_WIDTH-1:0]  col, col_nxt;
  logic [DIM_WIDTH-1:0]  row, row_nxt;
  logic [DIM_WIDTH-1:0]  blank_cnt, blank_nxt;
  logic [DATA_WIDTH-1:0] pix, pix_nxt;
  logic                  launch, frame_end;
  logic [DIM_WIDTH-1:0]  width_in, height_in, fblank_in;
  logic [DIM_WIDTH-1:0]  grad_sum;
  logic [DATA_WIDTH-1:0] pattern;

  // Zero sizes are clamped so every frame has at least one pixel and one
  // leading blank cycle.
  assign width_in  = (frame_width  == DIM_ZERO) ? DIM_ONE : frame_width;
  assign height_in = (frame_height == DIM_ZERO) ? DIM_ONE : frame_height;
  assign fblank_in = (frame_blank  == DIM_ZERO) ? DIM_ONE : frame_blank;
  assign grad_sum  = col_nxt + row_nxt;

  // Sequencer: next state, raster position and blank countdown.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    blank_nxt = blank_cnt;
    pix_nxt   = pix;
    launch    = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        launch = start | continuous;
      end
      S_FBLANK, S_LBLANK: begin
        if (blank_cnt != DIM_ZERO) begin
          blank_nxt = blank_cnt - DIM_ONE;
        end else if (state == S_FBLANK && lblank_q != DIM_ZERO) begin
          state_nxt = S_LBLANK;
          blank_nxt = lblank_q - DIM_ONE;
        end else begin
          state_nxt = S_ACTIVE;
          col_nxt   = DIM_ZERO;
        end
      end
      default: begin // S_ACTIVE
        pix_nxt = pix + PIX_ONE;
        if (col != width_q - DIM_ONE) begin
          col_nxt = col + DIM_ONE;
        end else if (row == height_q - DIM_ONE) begin
          frame_end = 1'b1;
          launch    = continuous;
          state_nxt = S_IDLE;
        end else begin
          row_nxt = row + DIM_ONE;
          col_nxt = DIM_ZERO;
          if (lblank_q != DIM_ZERO) begin
            state_nxt = S_LBLANK;
            blank_nxt = lblank_q - DIM_ONE;
          end
        end
      end
    endcase
    if (launch) begin
      state_nxt = S_FBLANK;
      blank_nxt = fblank_in - DIM_ONE;
      col_nxt   = DIM_ZERO;
      row_nxt   = DIM_ZERO;
      pix_nxt   = '0;
    end
  end

  // Pixel value for the position the sequencer is moving to.
  always_comb begin
    case (mode_q)
      MODE_COUNTER:  pattern = pix_nxt;
      MODE_GRADIENT: pattern = DATA_WIDTH'(grad_sum);
      MODE_CHECKER:  pattern = {DATA_WIDTH{col_nxt[0] ^ row_nxt[0]}};
      default:       pattern = const_q;
    endcase
  end

  // Sequencer state and raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
      pix       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      blank_cnt <= blank_nxt;
      pix       <= pix_nxt;
    end
  end

  // Frame configuration snapshot, taken only at launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q  <= '0;
      height_q <= '0;
      lblank_q <= '0;
      mode_q   <= '0;
      const_q  <= '0;
    end else if (launch) begin
      width_q  <= width_in;
      height_q <= height_in;
      lblank_q <= line_blank;
      mode_q   <= mode;
      const_q  <= const_value;
    end
  end

  // Registered sensor outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      data        <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= (state_nxt == S_LBLANK) || (state_nxt == S_ACTIVE);
      line_valid  <= (state_nxt == S_ACTIVE);
      data        <= (state_nxt == S_ACTIVE) ? pattern : '0;
      busy        <= (state_nxt != S_IDLE);
      frame_done  <= frame_end;
      if (frame_end) frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cmos_sensor_pattern_gen.sv
// Bench for cmos_sensor_pattern_gen: two instances (12-bit and 4-bit pixel
// buses) share stimulus; expected traces come from the frame timing and
// pattern rules computed with plain loops and arithmetic.
module tb_cmos_sensor_pattern_gen;

  localparam int DW   = 12;
  localparam int DW4  = 4;
  localparam int DIMW = 16;

  logic            clk = 1'b0;
  logic            reset, start, continuous;
  logic [1:0]      mode;
  logic [DW-1:0]   const_value;
  logic [DIMW-1:0] frame_width, frame_height, line_blank, frame_blank;

  logic            fv_a, lv_a, busy_a, done_a;
  logic [DW-1:0]   data_a;
  logic [31:0]     count_a;
  logic            fv_b, lv_b, busy_b, done_b;
  logic [DW4-1:0]  data_b;
  logic [31:0]     count_b;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit done_pending = 1'b0;
  int cyc_idx = 0;
  int poke_at = -1;
  int poke_kind = 0;
  int cfg_w, cfg_h, cfg_l, cfg_f, cfg_m, cfg_cv;

  always #5 clk = ~clk;

  cmos_sensor_pattern_gen #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW)) dut_a (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .mode(mode), .const_value(const_value),
    .frame_width(frame_width), .frame_height(frame_height),
    .line_blank(line_blank), .frame_blank(frame_blank),
    .frame_valid(fv_a), .line_valid(lv_a), .data(data_a), .busy(busy_a),
    .frame_done(done_a), .frame_count(count_a)
  );

  cmos_sensor_pattern_gen #(.DATA_WIDTH(DW4), .DIM_WIDTH(DIMW)) dut_b (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .mode(mode), .const_value(const_value[DW4-1:0]),
    .frame_width(frame_width), .frame_height(frame_height),
    .line_blank(line_blank), .frame_blank(frame_blank),
    .frame_valid(fv_b), .line_valid(lv_b), .data(data_b), .busy(busy_b),
    .frame_done(done_b), .frame_count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel value from the pattern rules.
  function automatic int pat(int m, int c, int r, int p, int cv, int dw);
    int modv;
    modv = 1 << dw;
    case (m)
      0:       return p % modv;
      1:       return (c + r) % modv;
      2:       return (((c + r) % 2) == 1) ? modv - 1 : 0;
      default: return cv % modv;
    endcase
  endfunction

  task automatic set_cfg(input int w, h, l, f, m, cv);
    cfg_w = w; cfg_h = h; cfg_l = l; cfg_f = f; cfg_m = m; cfg_cv = cv;
    frame_width  = DIMW'(w);
    frame_height = DIMW'(h);
    line_blank   = DIMW'(l);
    frame_blank  = DIMW'(f);
    mode         = 2'(m);
    const_value  = DW'(cv);
  endtask

  // One clock cycle: sample on the falling edge, then drive for the next edge.
  task automatic cyc(input bit efv, input bit elv, input bit ebusy, input int ea, input int eb);
    bit edone;
    @(negedge clk);
    edone = done_pending;
    if (done_pending) exp_count++;
    done_pending = 1'b0;
    chk("frame_valid", 32'(fv_a), 32'(efv));
    chk("line_valid", 32'(lv_a), 32'(elv));
    chk("busy", 32'(busy_a), 32'(ebusy));
    chk("frame_done", 32'(done_a), 32'(edone));
    chk("frame_count", count_a, 32'(exp_count));
    chk("data_12b", 32'(data_a), 32'(ea));
    chk("data_4b", 32'(data_b), 32'(eb));
    cyc_idx++;
    if (cyc_idx == 1) start = 1'b0;
    if (cyc_idx == poke_at) begin
      if (poke_kind == 1) continuous = 1'b0;
      if (poke_kind == 2) begin
        frame_width = DIMW'(8);
        start = 1'b1;
      end
    end else if (poke_kind == 2 && cyc_idx == poke_at + 1) begin
      start = 1'b0;
    end
  endtask

  // Whole frame body from the cycle after launch to the last pixel.
  task automatic run_frame(input bit chained);
    int wq, hq, fq, lq, m, cv, p;
    wq = (cfg_w == 0) ? 1 : cfg_w;
    hq = (cfg_h == 0) ? 1 : cfg_h;
    fq = (cfg_f == 0) ? 1 : cfg_f;
    lq = cfg_l; m = cfg_m; cv = cfg_cv; p = 0;
    cyc_idx = 0;
    done_pending = chained;
    for (int i = 0; i < fq; i++) cyc(1'b0, 1'b0, 1'b1, 0, 0);
    for (int r = 0; r < hq; r++) begin
      for (int i = 0; i < lq; i++) cyc(1'b1, 1'b0, 1'b1, 0, 0);
      for (int c = 0; c < wq; c++) begin
        cyc(1'b1, 1'b1, 1'b1, pat(m, c, r, p, cv, DW), pat(m, c, r, p, cv, DW4));
        p++;
      end
    end
  endtask

  task automatic finish_idle();
    done_pending = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic set_random_cfg();
    set_cfg($urandom_range(6, 0), $urandom_range(3, 0), $urandom_range(2, 0),
            $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(4095, 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    idle(2);

    // Single shot, counter pattern.
    set_cfg(4, 2, 2, 3, 0, 0);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();
    idle(2);

    // Continuous gradient frames; continuous cleared inside frame 3.
    set_cfg(3, 2, 0, 0, 1, 0);
    continuous = 1'b1;
    run_frame(1'b0);
    run_frame(1'b1);
    poke_kind = 1; poke_at = 3;
    run_frame(1'b1);
    poke_kind = 0; poke_at = -1;
    finish_idle();
    idle(2);

    // Checkerboard.
    set_cfg(4, 2, 1, 1, 2, 0);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();
    idle(1);

    // Width change and start pulse during a frame are ignored.
    set_cfg(4, 2, 1, 2, 0, 0);
    start = 1'b1;
    poke_kind = 2; poke_at = 4;
    run_frame(1'b0);
    poke_kind = 0; poke_at = -1;
    finish_idle();
    idle(2);
    set_cfg(8, 1, 1, 1, 0, 0);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();

    // Asynchronous reset in the middle of an active line.
    set_cfg(6, 2, 1, 1, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_lv", 32'(lv_a), 32'd1);
    chk("pre_reset_data", 32'(data_a), 32'd1);
    chk("pre_reset_count", count_a, 32'(exp_count));
    #1 reset = 1'b1;
    #1;
    chk("async_rst_fv", 32'(fv_a), 32'd0);
    chk("async_rst_lv", 32'(lv_a), 32'd0);
    chk("async_rst_data", 32'(data_a), 32'd0);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_count", count_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    done_pending = 1'b0;
    idle(4);

    // All-zero geometry clamps to one pixel after one blank cycle.
    set_cfg(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();

    // Counter wrap on the 4-bit instance.
    set_cfg(20, 1, 0, 1, 0, 0);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();

    // Constant pattern.
    set_cfg(3, 2, 1, 1, 3, 12'hA5C);
    start = 1'b1;
    run_frame(1'b0);
    finish_idle();

    // Randomized frames, single shot and back-to-back mixed.
    set_random_cfg();
    continuous = 1'($urandom_range(1, 0));
    start = 1'b1;
    run_frame(1'b0);
    for (int k = 0; k < 10; k++) begin
      continuous = 1'($urandom_range(1, 0));
      set_random_cfg();
      if (continuous) begin
        run_frame(1'b1);
      end else begin
        finish_idle();
        start = 1'b1;
        run_frame(1'b0);
      end
    end
    continuous = 1'b0;
    finish_idle();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_sensor_pattern_gen.md
Name: cmos_sensor_pattern_gen

Overview:
Parametrised successor to the fixed-format CMOS sensor output generator. It produces a synthetic camera stream (frame_valid / line_valid / pixel data) for the camera capture module. The following are runtime-configurable: frame size, blanking, and pattern mode (counter, gradient, checkerboard, constant). It supports single-shot and continuous operation and keeps a frame counter. It sits in the FPGA fabric next to the capture path and replaces a real sensor during bring-up and regression.

Parameters:
DATA_WIDTH, 12, pixel bus width in bits (1..16).
DIM_WIDTH, 16, width of the size, blank, row and column fields.

Ports:
clk  in  1  single system clock; all logic is in this domain.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; in IDLE, launches exactly one frame.
continuous  in  1  level; while high, frames repeat back-to-back.
mode  in  2  pattern select: 0 counter, 1 gradient, 2 checkerboard, 3 constant.
const_value  in  DATA_WIDTH  pixel value used in mode 3.
frame_width  in  DIM_WIDTH  active pixels per line (W).
frame_height  in  DIM_WIDTH  active lines per frame (H).
line_blank  in  DIM_WIDTH  cycles with frame_valid=1, line_valid=0 before each line (L).
frame_blank  in  DIM_WIDTH  cycles with frame_valid=0 before each frame (F).
frame_valid  out  1  sensor FVAL.
line_valid  out  1  sensor LVAL.
data  out  DATA_WIDTH  pixel data; 0 whenever line_valid=0.
busy  out  1  high from frame launch until frame end.
frame_done  out  1  one-cycle pulse after the last pixel of each frame.
frame_count  out  32  completed frames since reset; wraps at 2^32.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): state IDLE; all outputs 0; frame_count 0; row/col/pixel counters 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, FBLANK, LBLANK, ACTIVE.
- Configuration is latched at each frame launch; input changes mid-frame have no effect until the next frame.
- Zero clamping: W=0 → 1; H=0 → 1; F → max(F,1).
- L=0 means LBLANK is skipped.
- Launch from IDLE: at a clk edge where start=1 or continuous=1. If both are high, behaviour is the same as a single launch.
- Launch timing: starting in the cycle after the launch edge, busy=1 and the state is FBLANK.
- Frame timing, in cycles from launch:
  - max(F,1) cycles with fv=0.
  - then H repetitions of [L cycles fv=1,lv=0 ; W cycles fv=1,lv=1].
  - frame_valid falls together with line_valid after the last pixel; there is no trailing blank.
- Frame end cycle (the first cycle after the last pixel):
  - frame_done=1 and frame_count increments.
  - If continuous=1, the state goes to FBLANK of the next frame with new configuration latched and busy held at 1.
  - Otherwise the state goes to IDLE with busy=0.
- continuous deasserted mid-frame: the current frame completes normally, then the block returns to IDLE. Frames are never truncated.
- start while busy: ignored.
- Pattern rules (col = 0..W-1, row = 0..H-1, both zeroed at frame launch):
  - mode 0: data = pixel index within the frame, modulo 2^DATA_WIDTH; resets to 0 each frame.
  - mode 1: data = (col + row) truncated to DATA_WIDTH.
  - mode 2: data = all-ones if (col[0] ^ row[0]) else 0.
  - mode 3: data = const_value.
- mode is latched per frame, like the other configuration inputs.

Test Plan:
- Reset, then start with W=4, H=2, L=2, F=3, mode 0:
  - fv low for 3 cycles, then lv pattern 00 1111 00 1111.
  - data = 0,1,2,3 then 4,5,6,7.
  - fv drops with the last lv; frame_done=1 for one cycle; frame_count=1; busy=0.
- continuous=1 with W=3, H=2, L=0, F=0, mode 1:
  - exactly 1 fv-low cycle between frames.
  - data 0,1,2 / 1,2,3 each frame.
  - frame_count increments once per frame.
  - clearing continuous mid-frame 3 finishes frame 3, then busy=0 and frame_count=3.
- mode 2, W=4, H=2, DATA_WIDTH=12: line0 = 000,FFF,000,FFF; line1 = FFF,000,FFF,000.
- Mid-frame changes: frame_width changed to 8 and start pulsed during frame (W=4) → current frame keeps 4-pixel lines and no second launch occurs. The next launch uses W=8.
- reset asserted during ACTIVE → fv, lv, data, busy and frame_count go to 0 without waiting for a clock edge. After release the block stays IDLE until start.
- Clamping: W=0, H=0, F=0, L=0 → exactly one pixel with fv=lv=1, preceded by 1 blank cycle. mode 0 with DATA_WIDTH=4 and W=20 → data wraps 15→0.
